// File: rtl/hidden_neuron_mac.sv
// Serial multiply-accumulate hidden neuron: bias + sum(x*w), ReLU, rescale, saturate to OUT_W bits.
// Define HIDDEN_NEURON_SAT_FLAG_EN to add the sat_o saturation flag output.
module hidden_neuron_mac #(
    parameter int N_INPUTS  = 9,
    parameter int ACC_W     = 22,
    parameter int OUT_W     = 10,
    parameter int FRAC_BITS = 7
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [15:0]      bias_i,
    input  logic             in_valid_i,
    input  logic [7:0]       x_i,
    input  logic [7:0]       w_i,
    output logic             in_ready_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [OUT_W-1:0] act_o,
`ifdef HIDDEN_NEURON_SAT_FLAG_EN
    output logic             sat_o,
`endif
    output logic             busy_o
);

    localparam int CNT_W = $clog2(N_INPUTS + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_INPUTS - 1);
    localparam logic [ACC_W-1:0] ACT_MAX = {{(ACC_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};

    typedef enum logic [1:0] {IDLE, ACC, FINISH, DONE} state_t;

    state_t                   state, next_state;
    logic signed [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]         count;
    logic signed [16:0]       x_ext, w_ext, prod;
    logic [ACC_W-1:0]         q;
    logic                     sat_hit;
    logic [OUT_W-1:0]         result;
    logic                     accept;

    // x is unsigned, so a zero MSB keeps it positive in the signed product.
    assign x_ext  = {9'd0, x_i};
    assign w_ext  = {{9{w_i[7]}}, w_i};
    assign prod   = x_ext * w_ext;
    assign accept = (state == ACC) && in_valid_i;

    assign q       = $unsigned(acc) >> FRAC_BITS;
    assign sat_hit = !acc[ACC_W-1] && (q > ACT_MAX);

    always_comb begin
        result = '0;
        if (acc[ACC_W-1] || acc == '0) begin
            result = '0;
        end else if (sat_hit) begin
            result = '1;
        end else begin
            result = q[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        in_ready_o = 1'b0;
        busy_o     = 1'b1;
        case (state)
            IDLE: begin
                busy_o = 1'b0;
                if (start_i) next_state = ACC;
            end
            ACC: begin
                in_ready_o = 1'b1;
                if (in_valid_i && count == LAST_IDX) next_state = FINISH;
            end
            FINISH: next_state = DONE;
            DONE: begin
                if (out_valid_o && out_ready_i) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc         <= '0;
            count       <= '0;
            act_o       <= '0;
            out_valid_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        acc   <= {{(ACC_W-16){bias_i[15]}}, bias_i};
                        count <= '0;
                    end
                end
                ACC: begin
                    if (accept) begin
                        acc   <= acc + {{(ACC_W-17){prod[16]}}, prod};
                        count <= count + 1'b1;
                    end
                end
                FINISH: begin
                    act_o       <= result;
                    out_valid_o <= 1'b1;
                end
                DONE: begin
                    if (out_ready_i) out_valid_o <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef HIDDEN_NEURON_SAT_FLAG_EN
    // The flag outlives the handshake so it can be read until the next start.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sat_o <= 1'b0;
        end else if (state == IDLE && start_i) begin
            sat_o <= 1'b0;
        end else if (state == FINISH) begin
            sat_o <= sat_hit;
        end
    end
`endif

endmodule

// File: tb/tb_hidden_neuron_mac.sv
// Self-checking bench for hidden_neuron_mac: directed test-plan cases plus random evaluations
// compared against an integer-arithmetic reference model.
module tb_hidden_neuron_mac;

    logic       clk_i = 1'b0;
    logic       rst_i, start_i, in_valid_i, out_ready_i;
    logic [15:0] bias_i;
    logic [7:0] x_i, w_i;
    logic       in_ready_o, out_valid_o, busy_o;
    logic [9:0] act_o;
`ifdef HIDDEN_NEURON_SAT_FLAG_EN
    logic       sat_o;
`endif

    int checks = 0;
    int fails  = 0;
    int xs[9];
    int ws[9];
    int bias_v;
    int exp_act;
    int exp_sat;

    hidden_neuron_mac dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .bias_i      (bias_i),
        .in_valid_i  (in_valid_i),
        .x_i         (x_i),
        .w_i         (w_i),
        .in_ready_o  (in_ready_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .act_o       (act_o),
`ifdef HIDDEN_NEURON_SAT_FLAG_EN
        .sat_o       (sat_o),
`endif
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Reference: exact integer sum, ReLU, divide by 2^7, clamp at 1023.
    function automatic void computeExpected();
        int sum;
        int q;
        sum = bias_v;
        for (int i = 0; i < 9; i++) sum += xs[i] * ws[i];
        exp_act = 0;
        exp_sat = 0;
        if (sum > 0) begin
            q = sum / 128;
            if (q > 1023) begin
                exp_act = 1023;
                exp_sat = 1;
            end else begin
                exp_act = q;
            end
        end
    endfunction

    task automatic setCase(input int x, input int w, input int b);
        for (int i = 0; i < 9; i++) begin
            xs[i] = x;
            ws[i] = w;
        end
        bias_v = b;
        computeExpected();
    endtask

    task automatic setRandomCase();
        for (int i = 0; i < 9; i++) begin
            xs[i] = int'($urandom_range(0, 255));
            ws[i] = int'($urandom_range(0, 255)) - 128;
        end
        bias_v = int'($urandom_range(0, 65535)) - 32768;
        computeExpected();
    endtask

    task automatic startEval();
        @(negedge clk_i);
        start_i = 1'b1;
        bias_i  = 16'(bias_v);
        @(negedge clk_i);
        start_i = 1'b0;
        checkOutput("busy_after_start", busy_o, 1);
    endtask

    // bubble_mode: 0 none, 1 alternate valid/invalid, 2 random gaps
    task automatic applyStimulus(input int bubble_mode);
        for (int i = 0; i < 9; i++) begin
            if ((bubble_mode == 1 && i > 0) || (bubble_mode == 2 && $urandom_range(0, 1) == 1)) begin
                in_valid_i = 1'b0;
                x_i = 8'($urandom_range(0, 255));
                w_i = 8'($urandom_range(0, 255));
                @(negedge clk_i);
                checkOutput("out_valid_during_bubble", out_valid_o, 0);
            end
            in_valid_i = 1'b1;
            x_i = 8'(xs[i]);
            w_i = 8'(ws[i]);
            checkOutput("in_ready_acc", in_ready_o, 1);
            @(negedge clk_i);
        end
        in_valid_i = 1'b0;
        checkOutput("in_ready_finish", in_ready_o, 0);
        checkOutput("out_valid_early", out_valid_o, 0);
        @(negedge clk_i);
        checkOutput("out_valid_latency", out_valid_o, 1);
        checkOutput("act_result", act_o, 32'(exp_act));
        checkOutput("in_ready_done", in_ready_o, 0);
`ifdef HIDDEN_NEURON_SAT_FLAG_EN
        checkOutput("sat_flag", sat_o, 32'(exp_sat));
`endif
    endtask

    task automatic finishHandshake(input int hold_cycles, input bit poke_start);
        out_ready_i = 1'b0;
        for (int k = 0; k < hold_cycles; k++) begin
            start_i = poke_start && (k % 2 == 0);
            @(negedge clk_i);
            checkOutput("hold_act", act_o, 32'(exp_act));
            checkOutput("hold_valid", out_valid_o, 1);
            checkOutput("hold_busy", busy_o, 1);
        end
        start_i     = poke_start;
        out_ready_i = 1'b1;
        @(negedge clk_i);
        start_i     = 1'b0;
        out_ready_i = 1'b0;
        checkOutput("idle_valid", out_valid_o, 0);
        checkOutput("idle_busy", busy_o, 0);
        checkOutput("idle_act_kept", act_o, 32'(exp_act));
        checkOutput("idle_in_ready", in_ready_o, 0);
        @(negedge clk_i);
        checkOutput("idle_stays", busy_o, 0);
`ifdef HIDDEN_NEURON_SAT_FLAG_EN
        checkOutput("sat_kept_idle", sat_o, 32'(exp_sat));
`endif
    endtask

    initial begin
        rst_i = 1'b1;
        start_i = 1'b0;
        bias_i = '0;
        in_valid_i = 1'b0;
        x_i = '0;
        w_i = '0;
        out_ready_i = 1'b0;
        repeat (2) @(negedge clk_i);
        checkOutput("reset_act", act_o, 0);
        checkOutput("reset_valid", out_valid_o, 0);
        checkOutput("reset_ready", in_ready_o, 0);
        checkOutput("reset_busy", busy_o, 0);
`ifdef HIDDEN_NEURON_SAT_FLAG_EN
        checkOutput("reset_sat", sat_o, 0);
`endif
        rst_i = 1'b0;
        @(negedge clk_i);

        $display("[TB] case 1: x=10 w=0.5 bias 0");
        setCase(10, 64, 0);
        checkOutput("model_case1", 32'(exp_act), 45);
        startEval();
        applyStimulus(0);
        finishHandshake(0, 1'b0);

        $display("[TB] case 2: negative sum");
        setCase(100, -128, 0);
        startEval();
        applyStimulus(0);
        finishHandshake(1, 1'b0);

        $display("[TB] case 3: saturation");
        setCase(255, 127, 32767);
        checkOutput("model_case3", 32'(exp_act), 1023);
        startEval();
        applyStimulus(0);
        finishHandshake(0, 1'b0);

        $display("[TB] case 4: alternating bubbles");
        setCase(10, 64, 0);
        checkOutput("idle_in_ready_pre", in_ready_o, 0);
        startEval();
        applyStimulus(1);

        $display("[TB] case 5: backpressure with start pulses");
        finishHandshake(5, 1'b1);

        $display("[TB] case 6: reset mid-accumulation");
        startEval();
        for (int i = 0; i < 4; i++) begin
            in_valid_i = 1'b1;
            x_i = 8'(xs[i]);
            w_i = 8'(ws[i]);
            @(negedge clk_i);
        end
        in_valid_i = 1'b0;
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        checkOutput("midreset_act", act_o, 0);
        checkOutput("midreset_valid", out_valid_o, 0);
        checkOutput("midreset_ready", in_ready_o, 0);
        checkOutput("midreset_busy", busy_o, 0);
        @(negedge clk_i);
        startEval();
        applyStimulus(0);
        finishHandshake(0, 1'b0);

        $display("[TB] random evaluations");
        for (int n = 0; n < 12; n++) begin
            setRandomCase();
            startEval();
            applyStimulus(int'($urandom_range(0, 2)));
            finishHandshake(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/hidden_neuron_mac.md
Name: hidden_neuron_mac

Overview:
Sequential hidden-layer neuron that feeds the output neuron's 10-bit activation inputs (x0/x1).
- Accepts N_INPUTS (pixel, weight) pairs serially through a valid/ready handshake and multiply-accumulates them.
- Adds a bias, applies ReLU, rescales and saturates the result.
- Holds the 10-bit activation behind a valid/ready output handshake.
- One instance per hidden neuron.

Parameters:
N_INPUTS, 9, number of (x, w) pairs accumulated per evaluation (>=2)
ACC_W, 22, signed accumulator width
OUT_W, 10, unsigned activation output width
FRAC_BITS, 7, fractional bits of weights; right-shift applied after accumulation

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  reset, synchronous, active-high
start_i  input  1  pulse: begin a new evaluation (honoured only in IDLE)
bias_i  input  16  signed bias, same scale as x*w (Q8.7 aligned); sampled on accepted start_i
in_valid_i  input  1  x_i/w_i pair valid
x_i  input  8  unsigned input activation (integer)
w_i  input  8  signed weight, two's complement Q1.7
in_ready_o  output  1  pair accepted when in_valid_i && in_ready_o
out_valid_o  output  1  act_o valid
out_ready_i  input  1  consumer takes act_o
act_o  output  OUT_W  unsigned activation
busy_o  output  1  high in any state other than IDLE

Behaviour:
- Single clock domain, clk_i. Reset is synchronous and active-high on rst_i.
- Reset values: state=IDLE, acc=0, count=0, act_o=0, out_valid_o=0, in_ready_o=0, busy_o=0.
- Reset asserted in any state (including mid-accumulation or while holding a result) aborts the operation and returns all of the above to reset values at that edge.
- State machine: IDLE -> ACC -> FINISH -> DONE -> IDLE.
- IDLE:
  - start_i=1 -> acc<=sign-extended bias_i, count<=0, go to ACC.
  - act_o keeps its last value; out_valid_o=0.
- ACC:
  - in_ready_o=1 combinationally in this state only.
  - Each accepted pair: acc <= acc + signed(x_i zero-extended) * signed(w_i); count++.
  - The product is a 17-bit signed value, sign-extended to ACC_W.
  - Bubbles (in_valid_i=0) do not advance count.
  - The edge accepting pair number N_INPUTS moves to FINISH.
  - start_i is ignored.
- FINISH (one cycle, in_ready_o=0):
  - sum<=0 -> result 0.
  - Otherwise q = sum >> FRAC_BITS (truncate); result = min(q, 2^OUT_W-1).
  - At the edge: act_o<=result, out_valid_o<=1, go to DONE.
- DONE:
  - act_o and out_valid_o are held stable while out_ready_i=0.
  - out_valid_o && out_ready_i -> out_valid_o<=0, go to IDLE.
  - start_i is ignored in DONE, including the handshake cycle; a new start needs IDLE.
- Latency: out_valid_o rises at the second rising edge after the edge that accepted the last pair (FINISH occupies the cycle in between). Minimum evaluation is N_INPUTS+2 cycles from start_i to out_valid_o.
- Accumulator range: with defaults, the worst case |9*255*128 + 32768| < 2^21, so no accumulator wrap occurs. Wider N_INPUTS requires an ACC_W increase; behaviour on wrap is not defined.

Optional Feature:
- Macro: HIDDEN_NEURON_SAT_FLAG_EN.
- When defined, adds output port sat_o (1 bit).
  - Reset value 0; cleared when start_i is accepted.
  - Set in FINISH when q > 2^OUT_W-1 (the saturation path is taken).
  - Remains valid through DONE until the next start.
- When undefined, the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Defaults, bias 0, nine pairs x=10, w=0x40 (0.5), no bubbles -> sum 5760, act_o=45; out_valid_o exactly 2 edges after the 9th accept; sat_o=0.
- Nine pairs x=100, w=0x80 (-1.0), bias 0 -> sum negative, act_o=0, out_valid_o=1.
- Nine pairs x=255, w=0x7F, bias 0x7FFF -> sum 324232, q=2533, act_o=1023, sat_o=1 (when macro enabled).
- Case 1 with in_valid_i toggled 1/0 every other cycle -> exactly 9 accepts, act_o=45, in_ready_o low outside ACC.
- After a result: out_ready_i=0 for 5 cycles with start_i pulses -> act_o=45 and out_valid_o stable, start ignored; out_ready_i=1 -> IDLE next edge, busy_o=0.
- rst_i=1 for one cycle after 4 accepted pairs -> all outputs 0 and state IDLE next edge; rerun case 1 -> act_o=45.
